// File: rtl/audio_multi_timer.sv
// audio_multi_timer: NUM_CH independent prescaled interval timers behind one Avalon-MM slave,
// with a per-channel IRQ vector and a combined IRQ.
`timescale 1ns/1ps
module audio_multi_timer #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 99999,
  parameter int ADDR_W       = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);
  logic              wr;
  logic [ADDR_W-1:0] ch;
  logic [2:0]        rsel;
  logic [31:0]       rd_ch [NUM_CH];
  logic [31:0]       rd_nxt;
  assign wr   = chipselect && !write_n;
  assign ch   = address >> 3;
  assign rsel = address[2:0];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt, period, snap;
    logic [PRE_W-1:0] pre, pcnt;
    logic             ito, cont, run, to, fr, zero_d;
    logic             sel, tick, zero, start, stop;
    assign sel   = wr && ch == ADDR_W'(c);
    assign tick  = run && pcnt == '0;
    assign zero  = cnt == '0;
    assign start = sel && rsel == 3'd1 && writedata[2];
    assign stop  = sel && rsel == 3'd1 && writedata[3];
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cnt    <= RST_CNT;
        period <= RST_CNT;
        snap   <= '0;
        pre    <= '0;
        pcnt   <= '0;
        ito    <= 1'b0;
        cont   <= 1'b0;
        run    <= 1'b0;
        to     <= 1'b0;
        fr     <= 1'b0;
        zero_d <= 1'b0;
      end else begin
        fr     <= sel && rsel == 3'd2;
        zero_d <= zero;
        if (sel && rsel == 3'd1) {cont, ito} <= writedata[1:0];
        if (sel && rsel == 3'd2) period <= writedata[CNT_W-1:0];
        if (sel && rsel == 3'd3) snap <= cnt;
        if (sel && rsel == 3'd4) pre <= writedata[PRE_W-1:0];
        // a PERIOD write restarts both the count and the prescaler from the new values
        if (fr) begin
          cnt  <= period;
          pcnt <= pre;
        end else if (tick) begin
          cnt  <= zero ? period : cnt - CNT_W'(1);
          pcnt <= pre;
        end else if (run) pcnt <= pcnt - PRE_W'(1);
        run <= start ? 1'b1 : (stop || fr || (zero && !cont)) ? 1'b0 : run;
        to  <= (sel && rsel == 3'd0) ? 1'b0 : (zero && !zero_d) ? 1'b1 : to;
      end
    assign irq[c]   = to && ito;
    assign rd_ch[c] = ch != ADDR_W'(c) ? '0 :
                      rsel == 3'd0 ? {30'd0, run, to} :
                      rsel == 3'd1 ? {30'd0, cont, ito} :
                      rsel == 3'd2 ? 32'(period) :
                      rsel == 3'd3 ? 32'(snap) :
                      rsel == 3'd4 ? 32'(pre) : '0;
  end
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) rd_nxt |= rd_ch[i];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= rd_nxt;
  assign irq_any = |irq;
endmodule

// File: tb/tb_audio_multi_timer.sv
// tb_audio_multi_timer: directed and random bus traffic against a behavioural timer model.
`timescale 1ns/1ps
module tb_audio_multi_timer;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int RP = 99999;
  logic          clk = 0, reset_n = 1, chipselect = 0, write_n = 1;
  logic [AW-1:0] address = '0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [N-1:0]  irq;
  logic          irq_any;
  int checks = 0, errors = 0, cyc_n = 0;
  always #5 clk = ~clk;
  audio_multi_timer #(.NUM_CH(N), .CNT_W(32), .PRE_W(8), .RESET_PERIOD(RP), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq), .irq_any(irq_any)
  );
  int unsigned m_cnt[N], m_per[N], m_pre[N], m_pc[N], m_snap[N], m_rd;
  bit m_ito[N], m_cont[N], m_run[N], m_to[N], m_fr[N], m_z[N];
  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = RP; m_per[i] = RP; m_pre[i] = 0; m_pc[i] = 0; m_snap[i] = 0;
      m_ito[i] = 0; m_cont[i] = 0; m_run[i] = 0; m_to[i] = 0; m_fr[i] = 0; m_z[i] = 0;
    end
    m_rd = 0;
  endfunction
  function automatic int unsigned m_read(int a);
    int c, r;
    c = a >> 3; r = a & 7;
    if (c >= N) return 0;
    case (r)
      0: return {m_run[c], m_to[c]};
      1: return {m_cont[c], m_ito[c]};
      2: return m_per[c];
      3: return m_snap[c];
      4: return m_pre[c];
      default: return 0;
    endcase
  endfunction
  function automatic logic [31:0] m_irq();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_to[i] && m_ito[i];
    return v;
  endfunction
  function automatic void m_step(bit wr, int a, int unsigned d);
    int c, r;
    bit hit, zero, tick, strt, stp;
    c = a >> 3; r = a & 7;
    m_rd = m_read(a);
    for (int i = 0; i < N; i++) begin
      hit  = wr && c == i;
      zero = m_cnt[i] == 0;
      tick = m_run[i] && m_pc[i] == 0;
      strt = hit && r == 1 && d[2];
      stp  = hit && r == 1 && d[3];
      if (hit && r == 3) m_snap[i] = m_cnt[i];
      if (hit && r == 0) m_to[i] = 0;
      else if (zero && !m_z[i]) m_to[i] = 1;
      m_z[i] = zero;
      if (m_fr[i]) begin m_cnt[i] = m_per[i]; m_pc[i] = m_pre[i]; end
      else if (tick) begin m_cnt[i] = zero ? m_per[i] : m_cnt[i] - 1; m_pc[i] = m_pre[i]; end
      else if (m_run[i]) m_pc[i] = m_pc[i] - 1;
      if (strt) m_run[i] = 1;
      else if (stp || m_fr[i] || (zero && !m_cont[i])) m_run[i] = 0;
      m_fr[i] = hit && r == 2;
      if (hit && r == 2) m_per[i] = d;
      if (hit && r == 4) m_pre[i] = d & 255;
      if (hit && r == 1) begin m_ito[i] = d[0]; m_cont[i] = d[1]; end
    end
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic bus(input bit cs, input bit wn, input int a, input int unsigned d);
    chipselect = cs; write_n = wn; address = AW'(a); writedata = d;
    @(posedge clk);
    m_step(cs && !wn, a, d);
    cyc_n++;
    #1;
    chk("readdata", readdata, m_rd);
    chk("irq", 32'(irq), m_irq());
    chk("irq_any", 32'(irq_any), 32'(|m_irq()));
    chipselect = 0; write_n = 1;
  endtask
  task automatic cyc(input bit wr, input int a, input int unsigned d);
    bus(wr, !wr, a, d);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, rises, a, r;
    bit prev, found, cs, wn;
    int unsigned d;
    m_reset();
    #1 reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_irq_any", 32'(irq_any), 0);
    reset_n = 1;
    cyc(0, 2, 0);
    chk("ch0_period_rst", readdata, RP);
    cyc(0, 0, 0);
    chk("ch0_status_rst", readdata, 0);
    // ch1 continuous, 10-clk interval
    cyc(1, 12, 0); cyc(1, 10, 9); cyc(1, 9, 7);
    for (int k = 0; k < 40 && !irq[1]; k++) cyc(0, 0, 0);
    chk("ch1_first_irq", 32'(irq[1]), 1);
    chk("ch1_irq_any", 32'(irq_any), 1);
    t0 = cyc_n;
    cyc(1, 8, 0);
    chk("ch1_clear", 32'(irq[1]), 0);
    for (int k = 0; k < 40 && !irq[1]; k++) cyc(0, 0, 0);
    chk("ch1_interval", cyc_n - t0, 10);
    // ch2 one-shot with prescaler
    cyc(1, 20, 4); cyc(1, 18, 3); cyc(0, 0, 0); cyc(1, 17, 5);
    rises = 0; prev = irq[2];
    for (int k = 0; k < 60; k++) begin
      cyc(0, 0, 0);
      if (irq[2] && !prev) rises++;
      prev = irq[2];
    end
    chk("ch2_oneshot_count", rises, 1);
    cyc(0, 16, 0);
    chk("ch2_status", readdata, 1);
    cyc(1, 19, 0); cyc(0, 19, 0);
    chk("ch2_cnt_stays_0", readdata, 0);
    // START and STOP together
    cyc(1, 1, 12); cyc(0, 0, 0);
    chk("startstop_run", 32'(readdata[1]), 1);
    // STATUS write coinciding with a ch1 timeout event
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_cnt[1] == 0 && !m_z[1]) found = 1;
      else cyc(0, 0, 0);
    end
    chk("to_event_found", 32'(found), 1);
    cyc(1, 8, 0);
    chk("to_vs_status", 32'(irq[1]), 0);
    // ch0 PERIOD rewrite while running
    cyc(1, 2, 1000); cyc(0, 0, 0); cyc(1, 1, 4);
    repeat (5) cyc(0, 0, 0);
    cyc(1, 2, 50); cyc(0, 0, 0); cyc(1, 3, 0); cyc(0, 3, 0);
    chk("ch0_snap50", readdata, 50);
    cyc(0, 0, 0);
    chk("ch0_run_after_period", 32'(readdata[1]), 0);
    // out-of-range channel 3
    for (int k = 0; k < 8; k++) cyc(1, 24 + k, $urandom);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 24 + k, 0);
      chk("ch3_read", readdata, 0);
    end
    for (int k = 0; k < 32; k++) cyc(0, k, 0);
    // random traffic
    for (int k = 0; k < 600; k++) begin
      a = $urandom_range(0, 31); r = a & 7;
      cs = $urandom_range(0, 1); wn = $urandom_range(0, 3) != 0;
      d = r == 2 ? $urandom_range(0, 40) : r == 4 ? $urandom_range(0, 3) :
          r == 1 ? $urandom_range(0, 15) : $urandom;
      bus(cs, wn, a, d);
    end
    // async reset mid-count
    cyc(1, 12, 0); cyc(1, 10, 5); cyc(0, 0, 0); cyc(1, 9, 7);
    for (int k = 0; k < 40 && !irq[1]; k++) cyc(0, 0, 0);
    chk("pre_reset_irq", 32'(irq[1]), 1);
    #3 reset_n = 0;
    #1;
    m_reset();
    chk("async_irq", 32'(irq), 0);
    chk("async_irq_any", 32'(irq_any), 0);
    chk("async_readdata", readdata, 0);
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1;
    for (int c = 0; c < N; c++) begin
      cyc(1, c * 8 + 3, 0); cyc(0, c * 8 + 3, 0);
      chk("rst_counter", readdata, RP);
      cyc(0, c * 8 + 2, 0);
      chk("rst_period", readdata, RP);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
